// File: rtl/mccpu_hs.sv
// mccpu_hs: multicycle MIPS-subset core on a single ready-handshaked instruction/data memory port.
module mccpu_hs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] PC,
  output logic [31:0] instr,
  output logic        halted,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
);
  typedef enum logic [2:0] {FETCH, DECODE, EXE, MEM, WB, HALT} state_t;
  state_t state, state_nx;
  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic [31:0] gpr [32];
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, shamt;
  logic [31:0] sext, zext, rs_val, alu_i, alu_r, alu_res, rf_wd;
  logic is_r, is_jr, is_j, is_jal, is_beq, is_bne, is_lw, is_sw, is_alu_r, is_alu_i, legal, take, hs;
  logic rf_we;
  logic [4:0] rf_wa;
  assign op = ir[31:26];
  assign fn = ir[5:0];
  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign rd = ir[15:11];
  assign shamt = ir[10:6];
  assign sext = {{16{ir[15]}}, ir[15:0]};
  assign zext = {16'h0, ir[15:0]};
  assign rs_val = gpr[rs];
  assign is_r = op == 6'b000000;
  assign is_jr = is_r && fn == 6'b001000;
  assign is_alu_r = is_r && (fn inside {6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b000010});
  assign is_alu_i = op inside {6'b001001, 6'b001100, 6'b001101, 6'b001111};
  assign is_lw = op == 6'b100011;
  assign is_sw = op == 6'b101011;
  assign is_beq = op == 6'b000100;
  assign is_bne = op == 6'b000101;
  assign is_j = op == 6'b000010;
  assign is_jal = op == 6'b000011;
  assign legal = is_jr | is_alu_r | is_alu_i | is_lw | is_sw | is_beq | is_bne | is_j | is_jal;
  assign take = is_beq ? a == b : a != b;
  // lw/sw address generation shares the addiu path
  assign alu_i = op == 6'b001100 ? a & zext :
                 op == 6'b001101 ? a | zext :
                 op == 6'b001111 ? {ir[15:0], 16'h0} : a + sext;
  assign alu_r = fn == 6'b100011 ? a - b :
                 fn == 6'b100100 ? a & b :
                 fn == 6'b100101 ? a | b :
                 fn == 6'b101010 ? {31'd0, $signed(a) < $signed(b)} :
                 fn == 6'b000000 ? b << shamt :
                 fn == 6'b000010 ? b >> shamt : a + b;
  assign alu_res = is_r ? alu_r : alu_i;
  assign mem_req = !rst && (state == FETCH || state == MEM);
  assign mem_we = !rst && state == MEM && is_sw;
  assign mem_adr = state == MEM ? alu_out : pc;
  assign mem_wdata = b;
  assign hs = mem_req && mem_ready;
  assign halted = state == HALT;
  assign PC = pc;
  assign instr = ir;
  assign reg_data = reg_sel == 5'd0 ? 32'd0 : gpr[reg_sel];
  assign rf_we = state == WB || (state == DECODE && is_jal);
  assign rf_wa = state == DECODE ? 5'd31 : is_r ? rd : rt;
  assign rf_wd = state == DECODE ? pc : is_lw ? mdr : alu_out;
  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   state_nx = hs ? DECODE : FETCH;
      DECODE:  state_nx = !legal ? (HALT_ON_ILLEGAL ? HALT : FETCH) : (is_j | is_jal | is_jr) ? FETCH : EXE;
      EXE:     state_nx = (is_beq | is_bne) ? FETCH : (is_lw | is_sw) ? MEM : WB;
      MEM:     state_nx = !hs ? MEM : is_sw ? FETCH : WB;
      WB:      state_nx = FETCH;
      HALT:    state_nx = HALT;
      default: state_nx = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      ir <= '0;
      a <= '0;
      b <= '0;
      alu_out <= '0;
      mdr <= '0;
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else begin
      state <= state_nx;
      if (rf_we && rf_wa != 5'd0) gpr[rf_wa] <= rf_wd;
      if (state == FETCH && hs) begin
        ir <= mem_rdata;
        pc <= pc + 32'd4;
      end
      if (state == DECODE) begin
        a <= rs_val;
        b <= gpr[rt];
        if (is_j || is_jal) pc <= {pc[31:28], ir[25:0], 2'b00};
        if (is_jr) pc <= rs_val;
      end
      if (state == EXE) begin
        alu_out <= alu_res;
        if ((is_beq || is_bne) && take) pc <= pc + {sext[29:0], 2'b00};
      end
      if (state == MEM && hs && !is_sw) mdr <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mccpu_hs.sv
// tb_mccpu_hs: directed and random programs checked against an instruction-level model with scripted wait states.
module tb_mccpu_hs;
  logic clk = 1'b0, rst = 1'b1, rst2 = 1'b1;
  always #5 clk = ~clk;
  logic mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_adr, mem_wdata, mem_rdata, pc_o, instr, reg_data;
  logic [4:0] reg_sel = '0;
  logic mem_req2, mem_we2, halted2;
  logic [31:0] mem_adr2, mem_wdata2, mem_rdata2, pc2, instr2, reg_data2;
  logic [4:0] reg_sel2 = '0;
  logic [31:0] imem [0:1023];
  logic [31:0] dmem [0:15];
  logic [31:0] dinit [0:15];
  logic [31:0] mdm [0:15];
  logic [31:0] mr [0:31];
  logic [31:0] prog2 [0:7];
  int w [0:511];
  int k, waited, st_cnt;
  int tests = 0, fails = 0;

  mccpu_hs #(.RESET_PC(32'h3000), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .PC(pc_o),
    .instr(instr), .halted(halted), .reg_sel(reg_sel), .reg_data(reg_data));

  mccpu_hs #(.RESET_PC(32'h0), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .rst(rst2), .mem_req(mem_req2), .mem_we(mem_we2), .mem_adr(mem_adr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .mem_ready(1'b1), .PC(pc2),
    .instr(instr2), .halted(halted2), .reg_sel(reg_sel2), .reg_data(reg_data2));

  // program lives at 0x3000, data words at 0x00..0x3C
  assign mem_rdata = mem_adr[31:12] == 20'h3 ? imem[mem_adr[11:2]] : dmem[mem_adr[5:2]];
  assign mem_ready = mem_req && waited >= w[k % 512];
  assign mem_rdata2 = prog2[mem_adr2[4:2]];

  always @(posedge clk) begin
    if (rst) begin
      k <= 0;
      waited <= 0;
      st_cnt <= 0;
      for (int i = 0; i < 16; i++) dmem[i] <= dinit[i];
    end else if (mem_req && mem_ready) begin
      k <= k + 1;
      waited <= 0;
      if (mem_we) begin
        dmem[mem_adr[5:2]] <= mem_wdata;
        st_cnt <= st_cnt + 1;
      end
    end else if (mem_req) waited <= waited + 1;
  end

  function automatic logic [31:0] rt_(input logic [5:0] fn, input logic [4:0] rs, rt, rd, sh);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) mr[r] = v;
  endtask

  // instruction-level interpreter: final regs/data, cycles at zero wait, memory accesses, stores
  task automatic model_run(output int cyc, output int acc, output int sts);
    logic [31:0] pc, ir, se, ze, a, b, ad;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sh;
    bit done;
    pc = 32'h3000; cyc = 0; acc = 0; sts = 0; done = 0;
    for (int i = 0; i < 32; i++) mr[i] = '0;
    for (int i = 0; i < 16; i++) mdm[i] = dinit[i];
    for (int s = 0; s < 2000 && !done; s++) begin
      ir = imem[pc[11:2]]; pc = pc + 4; acc++;
      op = ir[31:26]; fn = ir[5:0]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11]; sh = ir[10:6];
      se = {{16{ir[15]}}, ir[15:0]}; ze = {16'h0, ir[15:0]};
      a = mr[rs]; b = mr[rt];
      if (op == 6'h00) begin
        case (fn)
          6'h21: begin wr(rd, a + b); cyc += 4; end
          6'h23: begin wr(rd, a - b); cyc += 4; end
          6'h24: begin wr(rd, a & b); cyc += 4; end
          6'h25: begin wr(rd, a | b); cyc += 4; end
          6'h2A: begin wr(rd, $signed(a) < $signed(b) ? 32'd1 : 32'd0); cyc += 4; end
          6'h00: begin wr(rd, b << sh); cyc += 4; end
          6'h02: begin wr(rd, b >> sh); cyc += 4; end
          6'h08: begin pc = a; cyc += 2; end
          default: begin cyc += 2; done = 1; end
        endcase
      end else begin
        case (op)
          6'h09: begin wr(rt, a + se); cyc += 4; end
          6'h0C: begin wr(rt, a & ze); cyc += 4; end
          6'h0D: begin wr(rt, a | ze); cyc += 4; end
          6'h0F: begin wr(rt, {ir[15:0], 16'h0}); cyc += 4; end
          6'h23: begin ad = a + se; wr(rt, mdm[ad[5:2]]); acc++; cyc += 5; end
          6'h2B: begin ad = a + se; mdm[ad[5:2]] = b; acc++; sts++; cyc += 4; end
          6'h04: begin if (a == b) pc = pc + (se << 2); cyc += 3; end
          6'h05: begin if (a != b) pc = pc + (se << 2); cyc += 3; end
          6'h02: begin pc = {pc[31:28], ir[25:0], 2'b00}; cyc += 2; end
          6'h03: begin wr(5'd31, pc); pc = {pc[31:28], ir[25:0], 2'b00}; cyc += 2; end
          default: begin cyc += 2; done = 1; end
        endcase
      end
    end
  endtask

  task automatic run_prog(input string tag, input bit first);
    int cyc, acc, sts, n, exp;
    logic pw, swe;
    logic [31:0] sa, sd;
    model_run(cyc, acc, sts);
    exp = cyc;
    for (int i = 0; i < acc; i++) exp += w[i];
    rst = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk({tag, "_rst_req"}, mem_req, 0);
    chk({tag, "_rst_we"}, mem_we, 0);
    chk({tag, "_rst_halted"}, halted, 0);
    chk({tag, "_rst_pc"}, pc_o, 32'h3000);
    chk({tag, "_rst_ir"}, instr, 0);
    rst = 1'b0;
    #1;
    chk({tag, "_fetch_req"}, mem_req, 1);
    chk({tag, "_fetch_adr"}, mem_adr, 32'h3000);
    n = 0; pw = 0; sa = '0; sd = '0; swe = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
      if (pw) begin
        chk({tag, "_hold_req"}, mem_req, 1);
        chk({tag, "_hold_adr"}, mem_adr, sa);
        chk({tag, "_hold_we"}, mem_we, swe);
        chk({tag, "_hold_wd"}, mem_wdata, sd);
      end
      if (first && n == 1) chk({tag, "_pc_after_fetch"}, pc_o, 32'h3004);
      if (first && n == 16) begin
        chk({tag, "_c16_adr"}, mem_adr, 32'h3010);
        chk({tag, "_c16_pc"}, pc_o, 32'h3010);
      end
      pw = mem_req && !mem_ready; sa = mem_adr; swe = mem_we; sd = mem_wdata;
    end while (!halted && n < 3000);
    chk({tag, "_cycles"}, n, exp);
    repeat (4) begin
      @(negedge clk);
      chk({tag, "_halt_req"}, mem_req, 0);
      chk({tag, "_halt_flag"}, halted, 1);
    end
    for (int r = 0; r < 32; r++) begin
      reg_sel = 5'(r);
      #1;
      chk($sformatf("%s_r%0d", tag, r), reg_data, mr[r]);
    end
    for (int i = 0; i < 16; i++) chk($sformatf("%s_d%0d", tag, i), dmem[i], mdm[i]);
    chk({tag, "_stores"}, st_cnt, sts);
  endtask

  task automatic rchk(input string tag, input logic [4:0] r, input logic [31:0] v);
    reg_sel = r;
    #1;
    chk(tag, reg_data, v);
  endtask

  initial begin
    logic [4:0] ra, rb, rc;
    for (int i = 0; i < 512; i++) w[i] = 0;
    for (int i = 0; i < 16; i++) dinit[i] = '0;
    for (int i = 0; i < 1024; i++) imem[i] = 32'hFFFF_FFFF;
    // non-halting core: illegal op is a NOP
    for (int i = 0; i < 8; i++) prog2[i] = '0;
    prog2[0] = 32'hFC00_0000;
    prog2[1] = it(6'h0D, 0, 1, 16'd7);
    prog2[2] = 32'h1000_FFFF;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("nop_halted", halted2, 0);
    chk("nop_req", mem_req2, 1);
    chk("nop_we", mem_we2, 0);
    chk("nop_adr", mem_adr2, 32'h4);
    chk("nop_pc", pc2, 32'h4);
    chk("nop_ir", instr2, 32'hFC00_0000);
    chk("nop_wdata", mem_wdata2, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reg_sel2 = 5'd1;
    #1;
    chk("nop_r1", reg_data2, 32'd7);
    // directed program with 3 wait cycles on the sw and lw data accesses
    imem[0] = it(6'h0D, 0, 1, 16'd5);
    imem[1] = it(6'h09, 1, 2, 16'hFFF9);
    imem[2] = rt_(6'h21, 1, 2, 3, 0);
    imem[3] = rt_(6'h2A, 2, 1, 4, 0);
    imem[4] = it(6'h09, 0, 0, 16'd9);
    imem[5] = it(6'h0F, 0, 6, 16'h1234);
    imem[6] = it(6'h2B, 0, 1, 16'd8);
    imem[7] = it(6'h23, 0, 5, 16'd8);
    imem[8] = it(6'h05, 1, 1, 16'd5);
    imem[9] = {6'h03, 26'h0000C0C};
    imem[12] = rt_(6'h00, 0, 1, 7, 3);
    imem[13] = rt_(6'h02, 0, 2, 8, 28);
    imem[14] = rt_(6'h23, 1, 2, 9, 0);
    imem[15] = rt_(6'h24, 2, 1, 10, 0);
    imem[16] = rt_(6'h25, 2, 1, 11, 0);
    imem[17] = it(6'h0C, 2, 12, 16'hFF00);
    imem[18] = rt_(6'h08, 31, 0, 0, 0);
    w[7] = 3; w[9] = 3;
    run_prog("dir", 1'b1);
    rchk("dir_add", 5'd3, 32'd3);
    rchk("dir_addiu", 5'd2, 32'hFFFF_FFFE);
    rchk("dir_slt", 5'd4, 32'd1);
    rchk("dir_lw", 5'd5, 32'd5);
    rchk("dir_lui", 5'd6, 32'h1234_0000);
    rchk("dir_jal", 5'd31, 32'h3028);
    rchk("dir_r0", 5'd0, 32'd0);
    rchk("dir_sll", 5'd7, 32'd40);
    chk("dir_mem8", dmem[2], 32'd5);
    // beq to itself keeps refetching the same word
    for (int i = 0; i < 512; i++) w[i] = 0;
    imem[0] = 32'h1000_FFFF;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 2; j++) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("beq_pc", pc_o, 32'h3000);
      chk("beq_adr", mem_adr, 32'h3000);
      chk("beq_req", mem_req, 1);
    end
    // random straight-line programs with forward branches and random wait states
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 1024; i++) imem[i] = 32'hFFFF_FFFF;
      for (int i = 0; i < 512; i++) w[i] = $urandom_range(0, 3);
      for (int i = 0; i < 16; i++) dinit[i] = $urandom;
      for (int i = 0; i < 4; i++) imem[i] = it(6'h0D, 0, 5'(i + 1), 16'($urandom));
      for (int i = 4; i < 28; i++) begin
        ra = 5'($urandom_range(0, 7)); rb = 5'($urandom_range(0, 7)); rc = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 14))
          0: imem[i] = rt_(6'h21, ra, rb, rc, 0);
          1: imem[i] = rt_(6'h23, ra, rb, rc, 0);
          2: imem[i] = rt_(6'h24, ra, rb, rc, 0);
          3: imem[i] = rt_(6'h25, ra, rb, rc, 0);
          4: imem[i] = rt_(6'h2A, ra, rb, rc, 0);
          5: imem[i] = rt_(6'h00, 0, rb, rc, 5'($urandom));
          6: imem[i] = rt_(6'h02, 0, rb, rc, 5'($urandom));
          7: imem[i] = it(6'h09, ra, rb, 16'($urandom));
          8: imem[i] = it(6'h0C, ra, rb, 16'($urandom));
          9: imem[i] = it(6'h0D, ra, rb, 16'($urandom));
          10: imem[i] = it(6'h0F, 0, rb, 16'($urandom));
          11: imem[i] = it(6'h23, 0, rb, 16'(4 * $urandom_range(0, 15)));
          12: imem[i] = it(6'h2B, 0, rb, 16'(4 * $urandom_range(0, 15)));
          13: imem[i] = it(6'h04, ra, rb, 16'($urandom_range(0, 2)));
          default: imem[i] = it(6'h05, ra, rb, 16'($urandom_range(0, 2)));
        endcase
      end
      run_prog($sformatf("rnd%0d", p), 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
